hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have port clock, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-003 SHALL have port id_signal_forwarding, input, 8, per-instruction register-usage vector from the ID-stage control unit, encoded per REQ-016.
REQ-004 SHALL have ports id_rs / id_rt / id_rd, input, 5 each, ID-stage register fields.
REQ-005 SHALL have port id_mem_read, input, 1, ID instruction is a load.
REQ-006 SHALL have port id_mul, input, 1, ID instruction is a MUL.
REQ-007 SHALL have ports if_stall / id_stall, output, 1 each, hold PC and IF/ID register; id_stall also feeds the control unit to inject a NOP.
REQ-008 SHALL have port ex_stall, output, 1, hold ID/EX and EX; bubble into EX/MEM.
REQ-009 SHALL have ports id_fwd_rs_sel / id_fwd_rt_sel, output, 2 each, ID comparator operand source: 00 regfile, 01 MEM result, 10 WB result.
REQ-010 SHALL have ports ex_fwd_rs_sel / ex_fwd_rt_sel, output, 2 each, registered EX operand source, same encoding.
REQ-011 SHALL have port mem_fwd_rt_sel, output, 1, store data from WB result when 1.
REQ-012 SHALL have parameter MUL_CYCLES, default 3, total EX occupancy of a MUL in cycles (>=1).

Function
REQ-013 SHALL keep three internal records: EX, MEM, WB; each holds dest register (5 bits) plus is_load and is_mul flags; dest 0 means "no write".
REQ-014 SHALL, on each cycle with no stall, shift ID->EX->MEM->WB; MEM leaves and is discarded after WB.
REQ-015 SHALL, when id_stall=1 and ex_stall=0, load a bubble (dest 0) into EX while EX->MEM->WB still shift.
REQ-016 SHALL decode id_signal_forwarding bits: [7] rs read in ID, [6] rs read in EX, [5] rt read in ID, [4] rt read in EX, [3] rt read in MEM (store), [2] dest=rd, [1] dest=rt, [0] dest=31; 8'h00 = NOP.
REQ-017 SHALL never report a hazard or non-zero select for register 0.
REQ-018 SHALL assert id_stall for a load-use hazard: EX.is_load and EX.dest matches an operand with a read bit in [7:4].
REQ-019 SHALL assert id_stall when an ID-read operand ([7] or [5]) matches EX.dest (any kind), or MEM.dest with MEM.is_load.
REQ-020 SHALL NOT stall for a store-data-only match ([3]); mem_fwd_rt_sel handles it from WB one cycle later.
REQ-021 SHALL, when a MUL enters EX, load an internal counter with MUL_CYCLES-1 and assert ex_stall while counter != 0, decrementing each cycle.
REQ-022 SHALL assert if_stall and id_stall whenever ex_stall=1; if_stall = id_stall at all times.
REQ-023 SHALL drive id_fwd_* combinationally, priority MEM (01) over WB (10) over regfile (00).
REQ-024 SHALL register ex_fwd_* on the ID->EX transfer: match against current EX.dest -> 01, else current MEM.dest -> 10, else 00; values are held during ex_stall.
REQ-025 SHALL register mem_fwd_rt_sel on the EX->MEM transfer when the EX instruction has bit [3] set and rt equals the current MEM.dest.
REQ-026 SHALL prioritize simultaneous conditions: ex_stall > load-use/ID stall > normal shift.

Reset
REQ-027 SHALL, on reset, clear all records to dest 0 with flags 0, zero the counter, and drive all outputs 0 on the following cycle.
REQ-028 SHALL abort an in-progress MUL stall on reset; reset overrides every other condition.

Structure
REQ-029 SHALL take the HAZ_* bit positions and forwarding-select encodings (00/01/10) from the shared constants package, next to the HAZ_* vectors of the control unit.
REQ-030 SHALL use one sub-module, hazard_record_stage, instantiated three times, holding one record with hold/bubble controls.

Verification
REQ-031 Load-use: LW $8 then ADD $9,$8,$1 -> id_stall=1 for exactly 1 cycle, then ex_fwd_rs_sel=10.
REQ-032 ALU chain: ADD $3 then SUB $4,$3,$3 -> no stall, ex_fwd_rs_sel=ex_fwd_rt_sel=01.
REQ-033 Branch: ADD $5 then BEQ $5,$0 -> 1-cycle stall, then id_fwd_rs_sel=01.
REQ-034 MUL, MUL_CYCLES=3: ex_stall=1 for 2 cycles, if_stall/id_stall=1, bubble in MEM, then normal flow.
REQ-035 Register 0: ADD $0 then ADD $2,$0,$0 -> all selects 00, no stall.
REQ-036 Reset asserted on 1st MUL stall cycle -> next cycle all outputs 0, counter 0.

Source files
------------

// File: rtl/hazard_unit_pkg.sv
// rtl/hazard_unit_pkg.sv - shared hazard-vector bit positions, forwarding encodings and record type
package hazard_unit_pkg;

  // Bit positions of the per-instruction register-usage vector from the control unit
  localparam int HAZ_RS_ID  = 7;
  localparam int HAZ_RS_EX  = 6;
  localparam int HAZ_RT_ID  = 5;
  localparam int HAZ_RT_EX  = 4;
  localparam int HAZ_RT_MEM = 3;
  localparam int HAZ_DST_RD = 2;
  localparam int HAZ_DST_RT = 1;
  localparam int HAZ_DST_RA = 0;

  localparam logic [7:0] HAZ_NOP    = 8'h00;
  localparam logic [7:0] HAZ_ALU_R  = 8'b0101_0100;
  localparam logic [7:0] HAZ_LOAD   = 8'b0100_0010;
  localparam logic [7:0] HAZ_STORE  = 8'b0100_1000;
  localparam logic [7:0] HAZ_BRANCH = 8'b1010_0000;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_MEM     = 2'b01;
  localparam logic [1:0] FWD_WB      = 2'b10;

  typedef struct packed {
    logic [4:0] dest;
    logic       is_load;
    logic       is_mul;
  } haz_rec_t;

  localparam haz_rec_t HAZ_BUBBLE = '{dest: 5'd0, is_load: 1'b0, is_mul: 1'b0};

  function automatic logic [4:0] haz_dest(input logic [7:0] sig, input logic [4:0] rt,
                                          input logic [4:0] rd);
    if (sig[HAZ_DST_RD]) return rd;
    else if (sig[HAZ_DST_RT]) return rt;
    else if (sig[HAZ_DST_RA]) return 5'd31;
    else return 5'd0;
  endfunction

  // Register 0 is never a real producer, so it can never match
  function automatic logic haz_match(input logic used, input logic [4:0] src,
                                     input logic [4:0] dest);
    return used && (src != 5'd0) && (src == dest);
  endfunction

endpackage

// File: rtl/hazard_record_stage.sv
// rtl/hazard_record_stage.sv - one pipeline destination record with hold and bubble controls
module hazard_record_stage
  import hazard_unit_pkg::*;
(
  input  logic     clock,
  input  logic     reset,
  input  logic     hold,
  input  logic     bubble,
  input  haz_rec_t d,
  output haz_rec_t q
);

  always_ff @(posedge clock) begin
    if (reset) begin
      q <= HAZ_BUBBLE;
    end else if (!hold) begin
      if (bubble) q <= HAZ_BUBBLE;
      else        q <= d;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - pipeline stall and forwarding-select generation
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int MUL_CYCLES = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] id_signal_forwarding,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [4:0] id_rd,
  input  logic       id_mem_read,
  input  logic       id_mul,
  output logic       if_stall,
  output logic       id_stall,
  output logic       ex_stall,
  output logic [1:0] id_fwd_rs_sel,
  output logic [1:0] id_fwd_rt_sel,
  output logic [1:0] ex_fwd_rs_sel,
  output logic [1:0] ex_fwd_rt_sel,
  output logic       mem_fwd_rt_sel
);

  localparam int CW = $clog2(MUL_CYCLES + 1);
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);

  haz_rec_t      id_rec, ex_rec, mem_rec, wb_rec;
  logic [CW-1:0] mul_cnt;
  logic [4:0]    ex_store_rt;
  logic          rs_any, rt_any, load_use, id_hazard;
  logic          unused_flags;

  assign id_rec = '{dest:    haz_dest(id_signal_forwarding, id_rt, id_rd),
                    is_load: id_mem_read,
                    is_mul:  id_mul};

  assign unused_flags = ^{ex_rec.is_mul, mem_rec.is_mul, wb_rec.is_load, wb_rec.is_mul};

  hazard_record_stage u_ex_rec (
    .clock  (clock),
    .reset  (reset),
    .hold   (ex_stall),
    .bubble (id_stall),
    .d      (id_rec),
    .q      (ex_rec)
  );

  hazard_record_stage u_mem_rec (
    .clock  (clock),
    .reset  (reset),
    .hold   (1'b0),
    .bubble (ex_stall),
    .d      (ex_rec),
    .q      (mem_rec)
  );

  hazard_record_stage u_wb_rec (
    .clock  (clock),
    .reset  (reset),
    .hold   (1'b0),
    .bubble (1'b0),
    .d      (mem_rec),
    .q      (wb_rec)
  );

  assign rs_any = id_signal_forwarding[HAZ_RS_ID] | id_signal_forwarding[HAZ_RS_EX];
  assign rt_any = id_signal_forwarding[HAZ_RT_ID] | id_signal_forwarding[HAZ_RT_EX];

  // Store data ([3]) is deliberately excluded: it is caught late from WB instead
  assign load_use = ex_rec.is_load &&
                    (haz_match(rs_any, id_rs, ex_rec.dest) ||
                     haz_match(rt_any, id_rt, ex_rec.dest));

  assign id_hazard =
      haz_match(id_signal_forwarding[HAZ_RS_ID], id_rs, ex_rec.dest) ||
      haz_match(id_signal_forwarding[HAZ_RT_ID], id_rt, ex_rec.dest) ||
      (mem_rec.is_load &&
       (haz_match(id_signal_forwarding[HAZ_RS_ID], id_rs, mem_rec.dest) ||
        haz_match(id_signal_forwarding[HAZ_RT_ID], id_rt, mem_rec.dest)));

  assign ex_stall = (mul_cnt != '0);
  assign id_stall = ex_stall | load_use | id_hazard;
  assign if_stall = id_stall;

  always_comb begin
    id_fwd_rs_sel = FWD_REGFILE;
    id_fwd_rt_sel = FWD_REGFILE;
    if (haz_match(id_signal_forwarding[HAZ_RS_ID], id_rs, mem_rec.dest))
      id_fwd_rs_sel = FWD_MEM;
    else if (haz_match(id_signal_forwarding[HAZ_RS_ID], id_rs, wb_rec.dest))
      id_fwd_rs_sel = FWD_WB;
    if (haz_match(id_signal_forwarding[HAZ_RT_ID], id_rt, mem_rec.dest))
      id_fwd_rt_sel = FWD_MEM;
    else if (haz_match(id_signal_forwarding[HAZ_RT_ID], id_rt, wb_rec.dest))
      id_fwd_rt_sel = FWD_WB;
  end

  // EX selects are taken against the producers one stage ahead of the incoming instruction
  function automatic logic [1:0] ex_sel(input logic used, input logic [4:0] src);
    if (haz_match(used, src, ex_rec.dest))       return FWD_MEM;
    else if (haz_match(used, src, mem_rec.dest)) return FWD_WB;
    else                                         return FWD_REGFILE;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      ex_fwd_rs_sel  <= FWD_REGFILE;
      ex_fwd_rt_sel  <= FWD_REGFILE;
      ex_store_rt    <= 5'd0;
      mem_fwd_rt_sel <= 1'b0;
    end else if (ex_stall) begin
      mem_fwd_rt_sel <= 1'b0;
    end else begin
      mem_fwd_rt_sel <= (ex_store_rt != 5'd0) && (ex_store_rt == mem_rec.dest);
      if (id_stall) begin
        ex_fwd_rs_sel <= FWD_REGFILE;
        ex_fwd_rt_sel <= FWD_REGFILE;
        ex_store_rt   <= 5'd0;
      end else begin
        ex_fwd_rs_sel <= ex_sel(id_signal_forwarding[HAZ_RS_EX], id_rs);
        ex_fwd_rt_sel <= ex_sel(id_signal_forwarding[HAZ_RT_EX], id_rt);
        ex_store_rt   <= id_signal_forwarding[HAZ_RT_MEM] ? id_rt : 5'd0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset)                   mul_cnt <= '0;
    else if (ex_stall)           mul_cnt <= mul_cnt - CW'(1);
    else if (id_mul && !id_stall) mul_cnt <= MUL_LOAD;
  end

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - directed self-checking bench for hazard_unit
module tb_hazard_unit;
  import hazard_unit_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] id_signal_forwarding = 8'h00;
  logic [4:0] id_rs = 5'd0, id_rt = 5'd0, id_rd = 5'd0;
  logic       id_mem_read = 1'b0, id_mul = 1'b0;
  logic       if_stall, id_stall, ex_stall, mem_fwd_rt_sel;
  logic [1:0] id_fwd_rs_sel, id_fwd_rt_sel, ex_fwd_rs_sel, ex_fwd_rt_sel;

  int checks = 0;
  int errors = 0;

  hazard_unit #(.MUL_CYCLES(3)) dut (
    .clock                (clock),
    .reset                (reset),
    .id_signal_forwarding (id_signal_forwarding),
    .id_rs                (id_rs),
    .id_rt                (id_rt),
    .id_rd                (id_rd),
    .id_mem_read          (id_mem_read),
    .id_mul               (id_mul),
    .if_stall             (if_stall),
    .id_stall             (id_stall),
    .ex_stall             (ex_stall),
    .id_fwd_rs_sel        (id_fwd_rs_sel),
    .id_fwd_rt_sel        (id_fwd_rt_sel),
    .ex_fwd_rs_sel        (ex_fwd_rs_sel),
    .ex_fwd_rt_sel        (ex_fwd_rt_sel),
    .mem_fwd_rt_sel       (mem_fwd_rt_sel)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_id(input logic [7:0] sig, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic mr, input logic mul);
    id_signal_forwarding = sig;
    id_rs = rs;
    id_rt = rt;
    id_rd = rd;
    id_mem_read = mr;
    id_mul = mul;
    #1;
  endtask

  task automatic nop();
    set_id(HAZ_NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic flush();
    nop();
    tick();
    tick();
    tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stalls"}, {29'd0, if_stall, id_stall, ex_stall}, 32'd0);
    chk({tag, "_id_fwd"}, {28'd0, id_fwd_rs_sel, id_fwd_rt_sel}, 32'd0);
    chk({tag, "_ex_fwd"}, {28'd0, ex_fwd_rs_sel, ex_fwd_rt_sel}, 32'd0);
    chk({tag, "_mem_fwd"}, {31'd0, mem_fwd_rt_sel}, 32'd0);
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    nop();
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk_all_zero("reset");

    // Load-use: LW $8,0($1) ; ADD $9,$8,$1
    set_id(HAZ_LOAD, 5'd1, 5'd8, 5'd0, 1'b1, 1'b0);
    chk("lu_lw_no_stall", {31'd0, id_stall}, 32'd0);
    tick();
    set_id(HAZ_ALU_R, 5'd8, 5'd1, 5'd9, 1'b0, 1'b0);
    chk("lu_id_stall", {31'd0, id_stall}, 32'd1);
    chk("lu_if_stall", {31'd0, if_stall}, 32'd1);
    chk("lu_ex_stall", {31'd0, ex_stall}, 32'd0);
    tick();
    chk("lu_stall_released", {31'd0, id_stall}, 32'd0);
    tick();
    nop();
    chk("lu_ex_fwd_rs", {30'd0, ex_fwd_rs_sel}, 32'd2);
    chk("lu_ex_fwd_rt", {30'd0, ex_fwd_rt_sel}, 32'd0);
    flush();

    // ALU chain: ADD $3,$1,$2 ; SUB $4,$3,$3
    set_id(HAZ_ALU_R, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
    tick();
    set_id(HAZ_ALU_R, 5'd3, 5'd3, 5'd4, 1'b0, 1'b0);
    chk("alu_no_stall", {31'd0, id_stall}, 32'd0);
    tick();
    nop();
    chk("alu_ex_fwd_rs", {30'd0, ex_fwd_rs_sel}, 32'd1);
    chk("alu_ex_fwd_rt", {30'd0, ex_fwd_rt_sel}, 32'd1);
    flush();

    // Branch: ADD $5,$1,$2 ; BEQ $5,$0
    set_id(HAZ_ALU_R, 5'd1, 5'd2, 5'd5, 1'b0, 1'b0);
    tick();
    set_id(HAZ_BRANCH, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("br_stall", {31'd0, id_stall}, 32'd1);
    tick();
    chk("br_stall_released", {31'd0, id_stall}, 32'd0);
    chk("br_id_fwd_rs", {30'd0, id_fwd_rs_sel}, 32'd1);
    chk("br_id_fwd_rt_r0", {30'd0, id_fwd_rt_sel}, 32'd0);
    flush();

    // WB forwarding into ID: ADD $6 ; NOP ; NOP ; BEQ $6,$6
    set_id(HAZ_ALU_R, 5'd1, 5'd2, 5'd6, 1'b0, 1'b0);
    tick();
    nop();
    tick();
    tick();
    set_id(HAZ_BRANCH, 5'd6, 5'd6, 5'd0, 1'b0, 1'b0);
    chk("wb_no_stall", {31'd0, id_stall}, 32'd0);
    chk("wb_id_fwd", {28'd0, id_fwd_rs_sel, id_fwd_rt_sel}, 32'b1010);
    flush();

    // MEM over WB priority: ADD $7 ; ADD $7 ; NOP ; BEQ $7,$7
    set_id(HAZ_ALU_R, 5'd1, 5'd2, 5'd7, 1'b0, 1'b0);
    tick();
    tick();
    nop();
    tick();
    set_id(HAZ_BRANCH, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0);
    chk("prio_no_stall", {31'd0, id_stall}, 32'd0);
    chk("prio_id_fwd", {28'd0, id_fwd_rs_sel, id_fwd_rt_sel}, 32'b0101);
    flush();

    // ID read of a load in MEM: LW $8 ; NOP ; BEQ $8,$0
    set_id(HAZ_LOAD, 5'd1, 5'd8, 5'd0, 1'b1, 1'b0);
    tick();
    nop();
    tick();
    set_id(HAZ_BRANCH, 5'd8, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("memld_stall", {31'd0, id_stall}, 32'd1);
    tick();
    chk("memld_released", {31'd0, id_stall}, 32'd0);
    chk("memld_id_fwd_rs", {30'd0, id_fwd_rs_sel}, 32'd2);
    flush();

    // Store data after load: LW $8 ; SW $8,0($1) -> no stall, store data from WB
    set_id(HAZ_LOAD, 5'd1, 5'd8, 5'd0, 1'b1, 1'b0);
    tick();
    set_id(HAZ_STORE, 5'd1, 5'd8, 5'd0, 1'b0, 1'b0);
    chk("st_no_stall", {31'd0, id_stall}, 32'd0);
    tick();
    nop();
    chk("st_mem_fwd_early", {31'd0, mem_fwd_rt_sel}, 32'd0);
    tick();
    chk("st_mem_fwd", {31'd0, mem_fwd_rt_sel}, 32'd1);
    flush();

    // MUL: ADD $11 ; MUL $10,$1,$2 ; ADD $12,$10,$1
    set_id(HAZ_ALU_R, 5'd1, 5'd2, 5'd11, 1'b0, 1'b0);
    tick();
    set_id(HAZ_ALU_R, 5'd1, 5'd2, 5'd10, 1'b0, 1'b1);
    chk("mul_enter_no_stall", {31'd0, ex_stall}, 32'd0);
    tick();
    set_id(HAZ_ALU_R, 5'd10, 5'd1, 5'd12, 1'b0, 1'b0);
    chk("mul_stall1", {29'd0, if_stall, id_stall, ex_stall}, 32'b111);
    tick();
    chk("mul_stall2", {29'd0, if_stall, id_stall, ex_stall}, 32'b111);
    chk("mul_mem_bubble", {27'd0, dut.mem_rec.dest}, 32'd0);
    tick();
    chk("mul_done", {29'd0, if_stall, id_stall, ex_stall}, 32'b000);
    tick();
    nop();
    chk("mul_ex_fwd_rs", {30'd0, ex_fwd_rs_sel}, 32'd1);
    chk("mul_in_mem", {27'd0, dut.mem_rec.dest}, 32'd10);
    chk("mul_flow_no_stall", {31'd0, ex_stall}, 32'd0);
    flush();

    // Register 0: ADD $0,$1,$2 ; ADD $2,$0,$0
    set_id(HAZ_ALU_R, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0);
    tick();
    set_id(HAZ_ALU_R, 5'd0, 5'd0, 5'd2, 1'b0, 1'b0);
    chk("r0_no_stall", {31'd0, id_stall}, 32'd0);
    chk("r0_id_fwd", {28'd0, id_fwd_rs_sel, id_fwd_rt_sel}, 32'd0);
    tick();
    nop();
    chk("r0_ex_fwd", {28'd0, ex_fwd_rs_sel, ex_fwd_rt_sel}, 32'd0);
    flush();

    // Reset during the first MUL stall cycle
    set_id(HAZ_ALU_R, 5'd2, 5'd3, 5'd1, 1'b0, 1'b0);
    tick();
    set_id(HAZ_ALU_R, 5'd1, 5'd2, 5'd10, 1'b0, 1'b1);
    tick();
    nop();
    chk("rstmul_stalling", {31'd0, ex_stall}, 32'd1);
    chk("rstmul_ex_fwd_before", {30'd0, ex_fwd_rs_sel}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk_all_zero("rstmul");
    chk("rstmul_counter", 32'(dut.mul_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
